// File: rtl/fb_pkg.sv
// Shared framebuffer constants, opcodes, FSM state encoding and the parsed-command record.
package fb_pkg;

  localparam int FB_PAGES = 8;
  localparam int FB_COLS  = 128;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] OP_SET_CURSOR = 8'h02;
  localparam logic [7:0] OP_RUN        = 8'h03;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ARG1,
    ST_ARG2,
    ST_FILL,
    ST_CLEAR
  } fb_state_e;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] arg1;
    logic [7:0] arg2;
  } fb_cmd_t;

endpackage

// File: rtl/fb_cmd_arbiter_if.sv
// Single-port framebuffer RAM bus; the arbiter is the master, the RAM the slave.
interface fb_cmd_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_wdata;
  logic              fb_we;
  logic [7:0]        fb_rdata;

  modport master (output fb_addr, output fb_wdata, output fb_we, input fb_rdata);
  modport slave  (input fb_addr, input fb_wdata, input fb_we, output fb_rdata);
endinterface

// File: rtl/fb_cmd_parser.sv
// UART byte parser: 1-entry pending buffer plus CMD/ARG1/ARG2 decode, emitting a one-cycle
// command strobe. Define FB_OVERRUN_CNT_EN to build the saturating dropped-byte counter.
import fb_pkg::*;

module fb_cmd_parser (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_received,
  input  logic [7:0] uart_rx_byte,
  input  logic       hold,
  output logic       cmd_valid,
  output fb_cmd_t    cmd,
  output logic       overrun,
  output logic [7:0] overrun_count
);
  fb_state_e  state, state_nx;
  logic       pend_valid;
  logic [7:0] pend_byte;
  logic [7:0] op_q, arg1_q;
  logic       take, drop;

  assign take = pend_valid && !hold;
  assign drop = uart_received && pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CMD;
      pend_valid <= 1'b0;
      pend_byte  <= '0;
      op_q       <= '0;
      arg1_q     <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) pend_valid <= 1'b0;
      if (uart_received && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_byte  <= uart_rx_byte;
      end
      if (drop) overrun <= 1'b1;
      if (take && state == ST_CMD) op_q <= pend_byte;
      if (take && state == ST_ARG1) arg1_q <= pend_byte;
    end
  end

  // The strobe is combinational so the top enters FILL/CLEAR on the same edge the last byte is consumed.
  always_comb begin
    state_nx  = state;
    cmd_valid = 1'b0;
    cmd       = '{op: op_q, arg1: arg1_q, arg2: pend_byte};
    if (take) begin
      case (state)
        ST_CMD: begin
          case (pend_byte)
            OP_NOP: state_nx = ST_CMD;
            OP_CLEAR: begin
              cmd_valid = 1'b1;
              cmd.op    = pend_byte;
            end
            OP_SET_CURSOR, OP_RUN: state_nx = ST_ARG1;
            default: state_nx = ST_CMD;
          endcase
        end
        ST_ARG1: state_nx = ST_ARG2;
        ST_ARG2: begin
          cmd_valid = 1'b1;
          state_nx  = ST_CMD;
        end
        default: state_nx = ST_CMD;
      endcase
    end
  end

`ifdef FB_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;

  always_ff @(posedge clk) begin
    if (rst) ovr_cnt <= '0;
    else if (drop && ovr_cnt != '1) ovr_cnt <= ovr_cnt + 8'd1;
  end

  assign overrun_count = ovr_cnt;
`else
  assign overrun_count = '0;
`endif

endmodule

// File: rtl/fb_cmd_arbiter.sv
// Framebuffer command arbiter: FILL/CLEAR write sequencing with strict display-read priority
// on the RAM port. Define FB_OVERRUN_CNT_EN to build the dropped-byte counter.
import fb_pkg::*;

module fb_cmd_arbiter #(
  parameter int FB_SIZE = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_received,
  input  logic [7:0]       uart_rx_byte,
  input  logic             d_frame_start,
  input  logic             d_read,
  output logic [7:0]       d_data,
  output logic             d_data_ready,
  fb_cmd_arbiter_if.master ram,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       overrun_count
);
  fb_state_e         state, state_nx;
  logic [ADDR_W-1:0] cursor, cursor_nx, read_ptr, rd_addr;
  logic [7:0]        fill_left, fill_left_nx, fill_val, fill_val_nx;
  logic              cmd_valid, rd_q, wr_go;
  fb_cmd_t           cmd;

  fb_cmd_parser u_parser (
    .clk           (clk),
    .rst           (rst),
    .uart_received (uart_received),
    .uart_rx_byte  (uart_rx_byte),
    .hold          (busy),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  assign busy = (state == ST_FILL) || (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_CMD;
      cursor       <= '0;
      fill_left    <= '0;
      fill_val     <= '0;
      read_ptr     <= '0;
      rd_q         <= 1'b0;
      d_data_ready <= 1'b0;
      d_data       <= '0;
    end else begin
      state        <= state_nx;
      cursor       <= cursor_nx;
      fill_left    <= fill_left_nx;
      fill_val     <= fill_val_nx;
      rd_q         <= d_read;
      d_data_ready <= rd_q;
      if (rd_q) d_data <= ram.fb_rdata;
      if (d_read) read_ptr <= rd_addr + 1'b1;
      else if (d_frame_start) read_ptr <= '0;
    end
  end

  // CLEAR walks the cursor itself from 0; its final increment wraps it back to 0.
  always_comb begin
    state_nx     = state;
    cursor_nx    = cursor;
    fill_left_nx = fill_left;
    fill_val_nx  = fill_val;
    rd_addr      = d_frame_start ? '0 : read_ptr;
    wr_go        = 1'b0;
    ram.fb_addr  = '0;
    ram.fb_we    = 1'b0;
    ram.fb_wdata = '0;

    if (!rst) begin
      if (d_read) begin
        ram.fb_addr = rd_addr;
      end else if (busy) begin
        wr_go        = 1'b1;
        ram.fb_addr  = cursor;
        ram.fb_we    = 1'b1;
        ram.fb_wdata = (state == ST_FILL) ? fill_val : '0;
      end
    end

    case (state)
      ST_FILL: begin
        if (wr_go) begin
          cursor_nx    = cursor + 1'b1;
          fill_left_nx = fill_left - 8'd1;
          if (fill_left == 8'd1) state_nx = ST_CMD;
        end
      end
      ST_CLEAR: begin
        if (wr_go) begin
          cursor_nx = cursor + 1'b1;
          if (cursor == ADDR_W'(FB_SIZE - 1)) state_nx = ST_CMD;
        end
      end
      default: begin
        if (cmd_valid) begin
          case (cmd.op)
            OP_CLEAR: begin
              state_nx  = ST_CLEAR;
              cursor_nx = '0;
            end
            OP_SET_CURSOR: begin
              cursor_nx = ADDR_W'((int'(cmd.arg1) % FB_PAGES) * FB_COLS
                                  + (int'(cmd.arg2) % FB_COLS));
            end
            OP_RUN: begin
              if (cmd.arg1 != 8'd0) begin
                state_nx     = ST_FILL;
                fill_left_nx = cmd.arg1;
                fill_val_nx  = cmd.arg2;
              end
            end
            default: state_nx = ST_CMD;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fb_cmd_arbiter.sv
// Randomised scoreboard bench for fb_cmd_arbiter with a command-level framebuffer model.
module tb_fb_cmd_arbiter;
  localparam int FB_SIZE = 1024;
  localparam int ADDR_W  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_received = 1'b0;
  logic [7:0] uart_rx_byte = '0;
  logic       d_frame_start = 1'b0;
  logic       d_read = 1'b0;
  logic [7:0] d_data, overrun_count;
  logic       d_data_ready, busy, overrun;

  fb_cmd_arbiter_if #(.ADDR_W(ADDR_W)) ram_if ();

  fb_cmd_arbiter #(.FB_SIZE(FB_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_received (uart_received),
    .uart_rx_byte  (uart_rx_byte),
    .d_frame_start (d_frame_start),
    .d_read        (d_read),
    .d_data        (d_data),
    .d_data_ready  (d_data_ready),
    .ram           (ram_if),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_mem [FB_SIZE];
  always @(posedge clk) begin
    if (ram_if.fb_we) ram_mem[ram_if.fb_addr] <= ram_if.fb_wdata;
    ram_if.fb_rdata <= ram_mem[ram_if.fb_addr];
  end

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int cyc;  int data; } rd_t;

  wr_t exp_wr_q[$];
  rd_t exp_rd_q[$];
  int  exp_ra_q[$];
  int  mdl_mem [FB_SIZE];
  int  mdl_cur = 0, mdl_rptr = 0;
  int  cyc = 0, nvec = 0, nerr = 0;
  int  busy_cnt = 0, wr_seen = 0, first_wr_cyc = -1, last_wr_cyc = -1;
  int  exp_oc;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin : monitor
    wr_t w;
    rd_t r;
    int  a;
    if (busy) busy_cnt++;
    if (d_read) begin
      if (exp_ra_q.size() == 0) chk("rd_addr_unexpected", int'(ram_if.fb_addr), -1);
      else begin
        a = exp_ra_q.pop_front();
        chk("rd_addr", int'(ram_if.fb_addr), a);
      end
      chk("rd_blocks_we", int'(ram_if.fb_we), 0);
    end
    if (ram_if.fb_we) begin
      if (exp_wr_q.size() == 0) chk("wr_unexpected", int'(ram_if.fb_addr), -1);
      else begin
        w = exp_wr_q.pop_front();
        chk("wr_addr", int'(ram_if.fb_addr), w.addr);
        chk("wr_data", int'(ram_if.fb_wdata), w.data);
      end
      wr_seen++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (d_data_ready) begin
      if (exp_rd_q.size() == 0) chk("rd_data_unexpected", int'(d_data), -1);
      else begin
        r = exp_rd_q.pop_front();
        chk("rd_data", int'(d_data), r.data);
        chk("rd_latency", cyc, r.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    uart_rx_byte  = b;
    uart_received = 1'b1;
    tick();
    uart_received = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic m_run(input int cnt, input int val);
    for (int i = 0; i < cnt; i++) begin
      exp_wr_q.push_back('{mdl_cur, val});
      mdl_mem[mdl_cur] = val;
      mdl_cur = (mdl_cur + 1) % FB_SIZE;
    end
  endtask

  task automatic do_run(input int cnt, input int val);
    m_run(cnt, val);
    send_byte(8'h03, 3);
    send_byte(8'(cnt), 3);
    send_byte(8'(val), 3);
  endtask

  task automatic do_set(input int page, input int col);
    mdl_cur = (page % 8) * 128 + (col % 128);
    send_byte(8'h02, 3);
    send_byte(8'(page), 3);
    send_byte(8'(col), 3);
  endtask

  task automatic do_clear();
    for (int i = 0; i < FB_SIZE; i++) begin
      exp_wr_q.push_back('{i, 0});
      mdl_mem[i] = 0;
    end
    mdl_cur = 0;
    send_byte(8'h01, 3);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_wr_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail("idle_timeout");
    repeat (3) tick();
  endtask

  task automatic read_burst(input int n, input bit fs);
    for (int i = 0; i < n; i++) begin
      d_read        = 1'b1;
      d_frame_start = fs && (i == 0);
      if (fs && i == 0) mdl_rptr = 0;
      exp_ra_q.push_back(mdl_rptr);
      exp_rd_q.push_back('{cyc + 2, mdl_mem[mdl_rptr]});
      mdl_rptr = (mdl_rptr + 1) % FB_SIZE;
      tick();
    end
    d_read        = 1'b0;
    d_frame_start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_d_data"},        int'(d_data), 0);
    chk({tag, "_d_data_ready"},  int'(d_data_ready), 0);
    chk({tag, "_fb_we"},         int'(ram_if.fb_we), 0);
    chk({tag, "_fb_addr"},       int'(ram_if.fb_addr), 0);
    chk({tag, "_fb_wdata"},      int'(ram_if.fb_wdata), 0);
    chk({tag, "_busy"},          int'(busy), 0);
    chk({tag, "_overrun"},       int'(overrun), 0);
    chk({tag, "_overrun_count"}, int'(overrun_count), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
`ifdef FB_OVERRUN_CNT_EN
    exp_oc = 2;
`else
    exp_oc = 0;
`endif
    for (int i = 0; i < FB_SIZE; i++) begin
      ram_mem[i] = '0;
      mdl_mem[i] = 0;
    end

    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // RUN from cursor 0 on an idle display
    busy_cnt = 0;
    first_wr_cyc = -1;
    do_run(5, 8'hAA);
    wait_idle(100);
    chk("run5_busy_cycles", busy_cnt, 5);
    chk("run5_consecutive", last_wr_cyc - first_wr_cyc, 4);
    do_run(1, 8'h33);
    wait_idle(100);

    // cursor at 1022 wrapping through 0
    do_set(8'h07, 8'h7E);
    do_run(4, 8'h55);
    wait_idle(100);

    // display reads during a RUN of 10
    do_set(3, 0);
    busy_cnt = 0;
    m_run(10, 8'h77);
    send_byte(8'h03, 3);
    send_byte(8'h0A, 3);
    send_byte(8'h77, 0);
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail("prio_busy_timeout");
    read_burst(3, 1'b1);
    wait_idle(100);
    chk("prio_busy_cycles", busy_cnt, 13);

    // randomised command mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0:       do_set(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        1, 2:    do_run(int'($urandom_range(0, 20)), int'($urandom_range(0, 255)));
        3:       send_byte(8'h00, 3);
        4:       send_byte(8'($urandom_range(4, 255)), 3);
        default: read_burst(int'($urandom_range(1, 16)), 1'($urandom_range(0, 1)));
      endcase
      wait_idle(200);
    end

    // overrun: one byte held, two dropped while FILL runs
    do_set(4, 0);
    do_run(255, 8'h11);
    uart_received = 1'b1;
    uart_rx_byte  = 8'h00;
    tick();
    uart_rx_byte  = 8'h01;
    tick();
    tick();
    uart_received = 1'b0;
    tick();
    chk("overrun_flag", int'(overrun), 1);
    chk("overrun_count", int'(overrun_count), exp_oc);
    wait_idle(400);
    chk("overrun_sticky", int'(overrun), 1);

    // reset in the middle of a RUN of 10
    base = wr_seen;
    exp_wr_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_wr_q.push_back('{(mdl_cur + i) % FB_SIZE, 8'h22});
      mdl_mem[(mdl_cur + i) % FB_SIZE] = 8'h22;
    end
    send_byte(8'h03, 3);
    send_byte(8'h0A, 3);
    send_byte(8'h22, 0);
    n = 0;
    while (wr_seen < base + 3 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail("reset_run_timeout");
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("midrun_reset");
    rst = 1'b0;
    mdl_cur  = 0;
    mdl_rptr = 0;
    repeat (12) tick();
    chk("midrun_no_more_writes", wr_seen, base + 3);
    do_run(2, 8'h5A);
    wait_idle(100);

    // CLEAR then read back the whole framebuffer
    busy_cnt = 0;
    do_clear();
    wait_idle(1200);
    chk("clear_busy_cycles", busy_cnt, FB_SIZE);
    read_burst(FB_SIZE, 1'b1);
    do_run(1, 8'h5C);
    wait_idle(100);
    read_burst(2, 1'b1);

    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
